// File: rtl/pool_window_unit.sv
// pool_window_unit: reduces one WIN_X x WIN_Y window of float32 values to
// either its mean (accumulate with a shared adder, then scale by RECIP) or
// its maximum (one sequential compare per cycle).
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   mode       0 = mean, 1 = max (captured when the window is accepted)
//   in_valid   upstream offers in_window/mode
//   in_ready   high only while idle; window accepted on in_valid & in_ready
//   in_window  element (x,y) at bits [32*(y*WIN_X+x) +: 32]
//   out_valid  out_data holds a result, held until out_ready
//   out_ready  downstream takes the result
//   out_data   float32 result
//   busy       high whenever the block is not idle
//
// Also contains pool_fp_unit, the start/done float32 add/multiply unit that
// the mean path shares. Subnormals flush to zero; rounding is nearest-even.

module pool_fp_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] result
);

  // m holds the normalized 24-bit significand, g the guard bit, st the
  // OR of everything below it.
  function automatic logic [31:0] fp_round(input logic s, input logic signed [9:0] e,
                                           input logic [23:0] m, input logic g,
                                           input logic st);
    logic [24:0]       mr;
    logic signed [9:0] er;
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 10'sd1;
    end
    if (er <= 10'sd0) return {s, 31'd0};
    if (er >= 10'sd255) return {s, 8'hFF, 23'd0};
    return {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
    logic [31:0]       x, y, t;
    logic [26:0]       mx, my;
    logic [27:0]       s;
    logic [7:0]        d;
    logic signed [9:0] e;
    logic [4:0]        lz;
    logic              found, stk;
    x = (a_in[30:23] == 8'd0) ? {a_in[31], 31'd0} : a_in;
    y = (b_in[30:23] == 8'd0) ? {b_in[31], 31'd0} : b_in;
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return {x[31] & y[31], 31'd0};
    if (x[30:0] == 31'd0) return y;
    if (y[30:0] == 31'd0) return x;
    if (y[30:0] > x[30:0]) begin
      t = x;
      x = y;
      y = t;
    end
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d >= 8'd27) begin
      my = 27'd1;
    end else begin
      stk = |(my & ~(27'h7FFFFFF << d));
      my  = (my >> d) | {26'd0, stk};
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == 28'd0) return 32'd0;
      found = 1'b0;
      lz    = 5'd0;
      for (int i = 26; i >= 0; i--) begin
        if (!found) begin
          if (s[i]) found = 1'b1;
          else lz = lz + 5'd1;
        end
      end
      s = s << lz;
      e = e - $signed({5'd0, lz});
    end
    return fp_round(x[31], e, s[26:3], s[2], |s[1:0]);
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a_in, input logic [31:0] b_in);
    logic              s;
    logic [47:0]       p;
    logic signed [9:0] e;
    s = a_in[31] ^ b_in[31];
    if (a_in[30:23] == 8'd0 || b_in[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a_in[22:0]} * {24'd0, 1'b1, b_in[22:0]};
    e = $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]}) - 10'sd127;
    if (p[47]) return fp_round(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= start;
      if (start) result <= (op == 2'b10) ? fmul(a, b) : fadd(a, b);
    end
  end

endmodule

module pool_window_unit #(
  parameter int          WIN_X = 2,
  parameter int          WIN_Y = 2,
  parameter logic [31:0] RECIP = 32'h3E800000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*WIN_X*WIN_Y-1:0] in_window,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     busy
);

  localparam int             N     = WIN_X * WIN_Y;
  localparam int             IW    = $clog2(N) + 1;
  localparam logic [IW-1:0]  N_IDX = IW'(N);

  typedef enum logic [2:0] {
    IDLE, ADD_START, ADD_WAIT, SCALE_START, SCALE_WAIT, CMP, OUT
  } state_t;

  state_t          state_q;
  logic [32*N-1:0] win_q;
  logic [31:0]     acc_q, out_data_q;
  logic [IW-1:0]   idx_q, idx_nxt;
  logic            in_ready_q, out_valid_q, busy_q;
  logic [31:0]     elem_cur, max_cand, add_res, mul_res;
  logic            add_start, mul_start, add_done, mul_done;

  // Sign-magnitude ordering; +0 and -0 are equal so a tie keeps acc.
  function automatic logic fgt(input logic [31:0] x, input logic [31:0] y);
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0) return 1'b0;
    if (x[31] != y[31]) return y[31];
    if (!x[31]) return x[30:0] > y[30:0];
    return x[30:0] < y[30:0];
  endfunction

  assign idx_nxt   = idx_q + 1'b1;
  assign elem_cur  = win_q[32*idx_q +: 32];
  assign max_cand  = fgt(elem_cur, acc_q) ? elem_cur : acc_q;
  assign add_start = (state_q == ADD_START);
  assign mul_start = (state_q == SCALE_START);

  pool_fp_unit u_add (
    .clk(clk), .resetn(resetn), .start(add_start), .op(2'b00),
    .a(acc_q), .b(elem_cur), .done(add_done), .result(add_res)
  );

  pool_fp_unit u_mul (
    .clk(clk), .resetn(resetn), .start(mul_start), .op(2'b10),
    .a(acc_q), .b(RECIP), .done(mul_done), .result(mul_res)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      win_q       <= '0;
      acc_q       <= 32'd0;
      idx_q       <= '0;
      out_data_q  <= 32'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            // Element 0 seeds the accumulator directly.
            win_q      <= in_window;
            acc_q      <= in_window[31:0];
            idx_q      <= IW'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (mode) begin
              if (N == 1) begin
                out_data_q  <= in_window[31:0];
                out_valid_q <= 1'b1;
                state_q     <= OUT;
              end else begin
                state_q <= CMP;
              end
            end else begin
              state_q <= (N == 1) ? SCALE_START : ADD_START;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ADD_START: state_q <= ADD_WAIT;
        ADD_WAIT: begin
          if (add_done) begin
            acc_q   <= add_res;
            idx_q   <= idx_nxt;
            state_q <= (idx_nxt == N_IDX) ? SCALE_START : ADD_START;
          end
        end
        SCALE_START: state_q <= SCALE_WAIT;
        SCALE_WAIT: begin
          if (mul_done) begin
            out_data_q  <= mul_res;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        CMP: begin
          acc_q <= max_cand;
          idx_q <= idx_nxt;
          if (idx_nxt == N_IDX) begin
            out_data_q  <= max_cand;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          // in_ready rises here so the next acceptance is one edge later.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: doc/pool_window_unit.md
Name: pool_window_unit

Overview:
- Parametrised successor of the 2x2 mean block. Accepts one WIN_X x WIN_Y window of IEEE-754 single-precision values and returns either the mean or the maximum of the window.
- Sits between the convolution/activation stage and the next layer in the forward-propagation datapath.
- Registers the whole window on acceptance, so upstream may change its inputs during computation.
- Uses valid/ready handshakes on both sides.

Parameters:
- WIN_X, 2, window width in elements (1..8).
- WIN_Y, 2, window height in elements (1..8).
- RECIP, 32'h3E800000, float32 value of 1/(WIN_X*WIN_Y); the integrator must set it consistently with WIN_X and WIN_Y.

Ports:
- clk  in  1  clock, rising-edge active.
- resetn  in  1  asynchronous active-low reset.
- mode  in  1  0 = mean, 1 = max; sampled at acceptance.
- in_valid  in  1  in_window and mode are valid.
- in_ready  out  1  block can accept a window.
- in_window  in  32*WIN_X*WIN_Y  element (x,y) sits at bits [32*(y*WIN_X+x) +: 32].
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  float32 result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE, in_ready=0 during reset, out_valid=0, out_data=0, busy=0, index=0, window registers=0. Reset mid-operation aborts the operation. The shared FP units are reset through the same resetn. No result is produced. After release the block is in IDLE with in_ready=1.
- N = WIN_X*WIN_Y. Elements are processed in index order 0..N-1.
- in_ready=1 only in IDLE. Acceptance is the rising edge with in_valid & in_ready. On that edge:
  - all N elements and mode are latched;
  - acc is set to element 0 directly (no add with 0);
  - index is set to 1.
- Mean datapath: one shared FPUnit, operation 2'b00 (add), firstOp=acc, secondOp=element[index]. A second FPUnit, operation 2'b10 (multiply), has firstOp=acc and secondOp=RECIP. Each unit takes a 1-cycle start pulse and signals done; the block waits on done with no fixed latency assumed.
- States (mean):
  - IDLE -> ADD_START on acceptance; -> SCALE_START instead if N=1.
  - ADD_START: pulse add start -> ADD_WAIT.
  - ADD_WAIT: on done, acc<=sum and index<=index+1. If the new index equals N -> SCALE_START, else -> ADD_START.
  - SCALE_START: pulse mul start -> SCALE_WAIT.
  - SCALE_WAIT: on done, out_data<=product -> OUT.
- States (max):
  - IDLE -> CMP on acceptance; -> OUT if N=1, with out_data=element 0.
  - CMP: one element per cycle. If element[index] > acc then acc<=element[index]. Increment index. When the last element is processed, out_data<=final max -> OUT.
  - max output appears N-1 cycles after the acceptance edge.
- Float compare:
  - Sign-magnitude ordering: a negative value is less than any positive value.
  - For two negatives, the larger magnitude is smaller.
  - +0 and -0 compare equal. On a tie, acc keeps its earlier value.
  - NaN inputs are out of scope.
- OUT: out_valid=1 and out_data held stable until out_ready=1. On the edge with out_valid & out_ready -> IDLE and out_valid=0. A new window can be accepted on the next edge at the earliest; there is no overlap of result and acceptance.
- in_valid while busy is ignored; upstream holds its data until in_ready.
- mode changes after acceptance have no effect on the current window.
- index width is clog2(N)+1. No wrap: the terminal check is index==N.

Test Plan:
- Mean, 2x2, elements {1.0,2.0,3.0,4.0} = 0x3F800000,0x40000000,0x40400000,0x40800000, mode=0 -> out_data=0x40200000 (2.5), out_valid held until out_ready.
- Max, same window, mode=1 -> out_data=0x40800000 after exactly 3 cycles. Then window {-1,-2,-3,-4} (0xBF800000,0xC0000000,0xC0400000,0xC0800000) -> 0xBF800000.
- All-zero window with mix of +0/-0, both modes -> mean 0x00000000 or 0x80000000 per FPUnit sign rule (value is zero); max equals element 0's encoding (tie keeps first).
- Backpressure: out_ready=0 for 10 cycles while in_window toggles and in_valid=1 -> out_data stable, in_ready=0, no second acceptance; release out_ready -> IDLE next edge, then accept the next window.
- Reset mid-ADD_WAIT (resetn low for 1 cycle, asynchronous, not clock-aligned) -> out_valid=0, out_data=0, busy=0 immediately; next window {2.0 x4} mean -> 0x40000000 with no stale accumulation.
- Parameter sweep WIN_X=3, WIN_Y=1, RECIP=0x3EAAAAAB, window {3.0,6.0,9.0} mean -> ~6.0 (0x40C00000 ±1 ulp); WIN_X=WIN_Y=1 with 5.0 -> 5.0 in both modes.
